// File: rtl/slt_seq_cmp.sv
// +-----------------------------------------------------------------------+
// | slt_seq_cmp: multi-cycle, multi-mode set-on-compare, MSB slice first   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module slt_seq_cmp #(
  parameter int WIDTH    = 32,
  parameter int CHUNK    = 8,
  parameter bit MASK_OUT = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                inA,
  input  logic [WIDTH-1:0]                inB,
  input  logic [2:0]                      mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                sltout,
  output logic                            flag,
  output logic                            err,
  output logic [$clog2(WIDTH/CHUNK):0]    ncmp
);

  localparam int N   = WIDTH / CHUNK;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int NCW = $clog2(N) + 1;
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TRUE_VAL = MASK_OUT ? {WIDTH{1'b1}} : WIDTH'(1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("slt_seq_cmp: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       mode_q;
  logic [KW-1:0]    k_q;
  logic [NCW-1:0]   ncmp_q, ncmp_d;
  logic [WIDTH-1:0] sltout_q, sltout_d;
  logic             flag_q, err_q, out_valid_q;

  logic [CHUNK-1:0] w_slice_a, w_slice_b;
  logic             w_lt, w_eq, w_hit, w_illegal;
  logic [WIDTH-1:0] w_flip;

  always_comb begin
    w_slice_a = a_q[int'(k_q)*CHUNK +: CHUNK];
    w_slice_b = b_q[int'(k_q)*CHUNK +: CHUNK];
    w_lt      = (w_slice_a < w_slice_b);
    // eq only feeds a result when this is the last slice, so it is the full-word equality
    w_eq      = (w_slice_a == w_slice_b);
    case (mode_q)
      3'b000, 3'b001: w_hit = w_lt;
      3'b010:         w_hit = w_eq;
      3'b011:         w_hit = !w_eq;
      3'b100, 3'b101: w_hit = !w_lt;
      default:        w_hit = 1'b0;
    endcase
    sltout_d  = w_hit ? TRUE_VAL : '0;
    ncmp_d    = ncmp_q + NCW'(1);
    w_illegal = mode[2] & mode[1];
    // Flipping the sign bit turns a signed compare into an unsigned one
    w_flip    = (mode[1:0] == 2'b00) ? SIGN_BIT : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      k_q         <= '0;
      ncmp_q      <= '0;
      sltout_q    <= '0;
      flag_q      <= 1'b1;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= inA ^ w_flip;
            b_q    <= inB ^ w_flip;
            mode_q <= mode;
            ncmp_q <= '0;
            if (w_illegal) begin
              sltout_q    <= '0;
              flag_q      <= 1'b1;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              k_q     <= KW'(N - 1);
              state_q <= S_CMP;
            end
          end
        end
        S_CMP: begin
          ncmp_q <= ncmp_d;
          if (!w_eq || (k_q == '0)) begin
            sltout_q    <= sltout_d;
            flag_q      <= !w_hit;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign sltout    = sltout_q;
  assign flag      = flag_q;
  assign err       = err_q;
  assign ncmp      = ncmp_q;

endmodule

`default_nettype wire

// File: tb/tb_slt_seq_cmp.sv
// +-----------------------------------------------------------------------+
// | tb_slt_seq_cmp: randomized + directed bench with behavioural model     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_slt_seq_cmp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // index 0: WIDTH=32 CHUNK=8 MASK_OUT=1, index 1: WIDTH=32 CHUNK=32 MASK_OUT=0
  logic        in_valid_a [2];
  logic        out_ready_a[2];
  logic [31:0] in_a_a     [2];
  logic [31:0] in_b_a     [2];
  logic [2:0]  mode_a     [2];

  logic        ir0, ov0, fl0, er0, ir1, ov1, fl1, er1;
  logic [31:0] so0, so1;
  logic [2:0]  nc0;
  logic [0:0]  nc1;

  logic        ir[2], ov[2], fl[2], er[2];
  logic [31:0] so[2];
  logic [2:0]  nc[2];

  assign ir[0] = ir0;  assign ir[1] = ir1;
  assign ov[0] = ov0;  assign ov[1] = ov1;
  assign fl[0] = fl0;  assign fl[1] = fl1;
  assign er[0] = er0;  assign er[1] = er1;
  assign so[0] = so0;  assign so[1] = so1;
  assign nc[0] = nc0;  assign nc[1] = {2'b00, nc1};

  slt_seq_cmp #(.WIDTH(32), .CHUNK(8), .MASK_OUT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(ir0),
    .inA(in_a_a[0]), .inB(in_b_a[0]), .mode(mode_a[0]), .out_valid(ov0),
    .out_ready(out_ready_a[0]), .sltout(so0), .flag(fl0), .err(er0), .ncmp(nc0)
  );

  slt_seq_cmp #(.WIDTH(32), .CHUNK(32), .MASK_OUT(1'b0)) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(ir1),
    .inA(in_a_a[1]), .inB(in_b_a[1]), .mode(mode_a[1]), .out_valid(ov1),
    .out_ready(out_ready_a[1]), .sltout(so1), .flag(fl1), .err(er1), .ncmp(nc1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-word compares, ncmp from position of the highest differing bit
  function automatic void model(input int chunk, input bit mask, input logic [2:0] m,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int ncmp_e, output bit err_e);
    int n;
    int msb;
    logic [31:0] diff;
    bit t;
    n = 32 / chunk;
    if (m == 3'b110 || m == 3'b111) begin
      res = 32'h0; ncmp_e = 0; err_e = 1'b1;
      return;
    end
    err_e = 1'b0;
    diff  = a ^ b;
    msb   = -1;
    for (int i = 31; i >= 0; i--) begin
      if (diff[i] && msb < 0) msb = i;
    end
    ncmp_e = (msb < 0) ? n : n - (msb / chunk);
    case (m)
      3'b000:  t = ($signed(a) < $signed(b));
      3'b001:  t = (a < b);
      3'b010:  t = (a == b);
      3'b011:  t = (a != b);
      3'b100:  t = !($signed(a) < $signed(b));
      default: t = !(a < b);
    endcase
    res = t ? (mask ? 32'hFFFF_FFFF : 32'h1) : 32'h0;
  endfunction

  task automatic do_op(input int d, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] b, input int bp);
    logic [31:0] res_e;
    int ncmp_e, w, lat;
    bit err_e;
    model((d == 0) ? 8 : 32, (d == 0), m, a, b, res_e, ncmp_e, err_e);
    w = 0;
    while (!ir[d] && w < 50) begin @(posedge clk); #1; w++; end
    chk("in_ready_before_op", 32'(ir[d]), 32'h1);
    in_valid_a[d] = 1'b1; in_a_a[d] = a; in_b_a[d] = b; mode_a[d] = m;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0; in_a_a[d] = $urandom; in_b_a[d] = $urandom;
    mode_a[d] = 3'($urandom);
    lat = 0;
    while (!ov[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), err_e ? 32'h0 : 32'(ncmp_e));
    chk("sltout", so[d], res_e);
    chk("flag", 32'(fl[d]), 32'(res_e == 32'h0));
    chk("err", 32'(er[d]), 32'(err_e));
    chk("ncmp", 32'(nc[d]), 32'(ncmp_e));
    chk("in_ready_busy", 32'(ir[d]), 32'h0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(ov[d]), 32'h1);
      chk("bp_sltout", so[d], res_e);
      chk("bp_flag", 32'(fl[d]), 32'(res_e == 32'h0));
      chk("bp_ncmp", 32'(nc[d]), 32'(ncmp_e));
      chk("bp_in_ready", 32'(ir[d]), 32'h0);
    end
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
    chk("post_hs_out_valid", 32'(ov[d]), 32'h0);
    chk("post_hs_in_ready", 32'(ir[d]), 32'h1);
    chk("post_hs_sltout_kept", so[d], res_e);
  endtask

  task automatic chk_reset(input int d);
    chk("rst_out_valid", 32'(ov[d]), 32'h0);
    chk("rst_sltout", so[d], 32'h0);
    chk("rst_flag", 32'(fl[d]), 32'h1);
    chk("rst_err", 32'(er[d]), 32'h0);
    chk("rst_ncmp", 32'(nc[d]), 32'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0] m;
    int d;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b0;
      in_a_a[i] = '0; in_b_a[i] = '0; mode_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0); chk_reset(1);
    chk("rst_in_ready", 32'(ir[0]), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(ir[0]), 32'h1);

    do_op(0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(0, 3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(0, 3'b010, 32'h1234_5678, 32'h1234_5678, 1);
    do_op(0, 3'b001, 32'h1234_5678, 32'h1234_5679, 0);
    do_op(0, 3'b101, 32'h1234_5678, 32'h1234_5679, 5);
    do_op(0, 3'b111, 32'd5, 32'd3, 2);
    do_op(0, 3'b011, 32'd5, 32'd3, 0);
    do_op(0, 3'b110, 32'h8000_0000, 32'h0, 0);
    do_op(1, 3'b000, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    do_op(1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 3);
    do_op(1, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

    // Reset in the middle of a compare, with a nonzero result still held
    do_op(0, 3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    in_valid_a[0] = 1'b1; in_a_a[0] = 32'h0; in_b_a[0] = 32'h0; mode_a[0] = 3'b010;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(ir[0]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_reset(0);
      chk("rst_mid_in_ready_hold", 32'(ir[0]), 32'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(ir[0]), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale_out_valid", 32'(ov[0]), 32'h0);
    end

    for (int it = 0; it < 120; it++) begin
      d = int'($urandom_range(0, 1));
      m = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ 32'h8000_0000;
      endcase
      do_op(d, m, a, b, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slt_seq_cmp.md
Name: slt_seq_cmp

Overview:
- Parametrised, multi-mode, multi-cycle set-on-compare unit. Generational successor of the combinational 32-bit signed set-less-than.
- Compares WIDTH-bit operands CHUNK bits per cycle, MSB slice first, and terminates early on the first differing slice.
- Sits behind the ALU issue logic with valid/ready handshakes on both sides.
- Emits the set result plus a zero flag, same sense as the existing ALU flag.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; N = WIDTH/CHUNK slices.
MASK_OUT, 1, 1: true result is all ones; 0: true result is 1 (zero-extended).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request.
inA  in  WIDTH  operand A.
inB  in  WIDTH  operand B.
mode  in  3  000 SLT (signed), 001 SLTU, 010 SEQ, 011 SNE, 100 SGE (signed), 101 SGEU; 110/111 illegal.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sltout  out  WIDTH  set result.
flag  out  1  1 when sltout == 0.
err  out  1  illegal mode for the current result.
ncmp  out  clog2(N)+1  slices examined for the current result.

Behaviour:
- Reset: sampled on rising clk while rst_n=0; takes priority over everything, including mid-compare; the in-flight operation is discarded.
- Reset values: state=IDLE, out_valid=0, sltout=0, flag=1, err=0, ncmp=0.
- in_ready = rst_n && (state==IDLE), combinational from state.
- FSM states: IDLE, CMP, DONE.
- IDLE, capture on in_valid && in_ready:
  - Register A, B and mode.
  - Signed modes (SLT/SGE): invert bit WIDTH-1 of both captured operands, so the remaining compare is purely unsigned.
  - Legal mode: slice index k ← N-1, ncmp ← 0, state ← CMP.
  - Illegal mode: sltout ← 0, flag ← 1, err ← 1, ncmp ← 0, state ← DONE; out_valid is visible the cycle after capture.
- CMP, each cycle:
  - Compare A[k*CHUNK +: CHUNK] with B[k*CHUNK +: CHUNK] (unsigned); ncmp ← ncmp+1.
  - Slices differ: lt = (sliceA < sliceB), eq = 0; state ← DONE.
  - Slices equal and k==0: lt = 0, eq = 1; state ← DONE.
  - Otherwise k ← k-1 and stay in CMP.
  - Latency from capture edge to out_valid=1 equals the number of slices examined: 1..N cycles; equal operands always take N.
- Result mapping:
  - SLT/SLTU: lt. SGE/SGEU: !lt. SEQ: eq. SNE: !eq.
  - True → all ones if MASK_OUT=1, else 1. False → 0.
  - sltout, flag, err and ncmp are registered together on entry to DONE; err=0 for legal modes.
- DONE:
  - out_valid=1. sltout, flag, err and ncmp are held stable while out_ready=0.
  - On out_valid && out_ready: state ← IDLE, out_valid ← 0; outputs retain their last values.
  - in_ready rises the cycle after the output handshake; no same-cycle accept. Peak throughput: one op per (d+2) cycles, where d = slices examined.
- Input changes while not in IDLE are ignored. in_valid held with no capture has no effect.
- N=1 (CHUNK=WIDTH) is legal: every legal op takes exactly 1 CMP cycle.

Test Plan:
(WIDTH=32, CHUNK=8, MASK_OUT=1 unless stated)
1. Reset: assert rst_n=0 for 3 cycles while in CMP → out_valid=0, sltout=0, flag=1, err=0, ncmp=0, in_ready=0 during reset; in_ready=1 the first cycle after rst_n=1; no stale result appears.
2. SLT, A=0xFFFFFFFF (-1), B=0x00000001 → sltout=0xFFFFFFFF, flag=0, ncmp=1, out_valid 1 cycle after capture. Same operands with SLTU → sltout=0, flag=1, ncmp=1.
3. SEQ, A=B=0x12345678 → sltout=0xFFFFFFFF, flag=0, ncmp=4, latency 4. SLTU, A=0x12345678, B=0x12345679 → sltout=0xFFFFFFFF, ncmp=4. SGEU on the same operands → sltout=0, flag=1.
4. Backpressure: after a result, hold out_ready=0 for 5 cycles → out_valid, sltout, flag, ncmp stable and in_ready=0; raise out_ready → handshake, in_ready=1 next cycle. Back-to-back in_valid is accepted only then.
5. Illegal mode 3'b111, A=5, B=3 → out_valid after 1 cycle, err=1, sltout=0, flag=1, ncmp=0. Next op SNE, A=5, B=3 → err=0, sltout=0xFFFFFFFF, ncmp=4.
6. MASK_OUT=0, CHUNK=32: SLT, A=0x80000000, B=0x7FFFFFFF → sltout=0x00000001, flag=0, ncmp=1. SGE on the same operands → sltout=0, flag=1.
